pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
- Parametrised multi-stage register pipeline with valid/ready handshake and bubble collapsing. Generalises the single enable register to depth STAGES with per-stage backpressure.
- Each stage holds one WIDTH-bit word plus a valid bit. Empty stages are filled even while the output is stalled.
- Used between datapath blocks for timing (register slicing) and short elastic buffering. Also provides synchronous flush and occupancy reporting.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- STAGES, 3, number of register stages (>=1); also the maximum number of words held.
- CW, $clog2(STAGES+1), width of the occupancy count (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; clock clk.
- flush  input  1  synchronous clear of all stage valids; active high.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  stage STAGES-1 holds a word.
- out_data  output  WIDTH  word in stage STAGES-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  CW  number of valid stages (0..STAGES).

Behaviour:
- Storage: v[i], d[i] for i = 0..STAGES-1. Stage 0 is the input side, stage STAGES-1 the output side.
- Reset (rst=0, asynchronous): all v[i]=0, all d[i]=0. Outputs: out_valid=0, out_data=0, count=0. in_ready=1 as soon as rst deasserts.
- Advance terms (combinational):
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1] for i < STAGES-1.
- in_ready = adv[0] & !flush.
- Accept: in_valid & in_ready.
- Per-edge update when flush=0:
  - Stage 0: if adv[0], then d[0] <= in_data and v[0] <= in_valid.
  - Stage i>0: if adv[i], then d[i] <= d[i-1] and v[i] <= v[i-1].
  - When adv[i]=0, stage i holds d[i] and v[i] unchanged.
- Data register loads only when its source valid is 1. Bubbles do not overwrite d[i], which keeps toggling low.
- Output: out_valid = v[STAGES-1], out_data = d[STAGES-1]. Both are registered; there is no combinational in-to-out path.
- Hold rule: while out_valid=1 and out_ready=0, out_data must stay stable. out_valid must not drop unless flush or reset.
- Latency: a word accepted at edge N into an empty pipeline, with out_ready=1, appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles from in_valid assertion.
- Throughput: one word per cycle sustained when out_ready=1.
- Bubble collapsing: with out_ready=0, new words are accepted until all STAGES valids are 1 (count=STAGES). in_ready falls only when full.
- Full with out_ready=1: the chain shifts, and in_ready=1 in the same cycle (combinational path from out_ready to in_ready is intended).
- Flush (synchronous, priority over all handshakes):
  - Next edge: all v[i]=0 and count=0. No word is accepted, and in_ready=0 during the flush cycle.
  - out_valid may be 1 in the flush cycle. A transfer with out_ready=1 in that cycle counts as delivered.
  - d[i] are not cleared.
- count: registered. Next value = count + accept - (out_valid & out_ready). Simultaneous accept and deliver leaves count unchanged. Flush forces 0.
- Invariant: count equals popcount(v); a mismatch is an assertion failure.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). No partial state survives.
- STAGES=1: degenerates to a single full-throughput slice with in_ready = !v[0] | out_ready.

Test Plan:
- Reset/idle: hold rst=0 with in_valid=1, in_data=8'hFF -> out_valid=0, out_data=0, count=0. After release, in_ready=1 and the first word exits STAGES=3 cycles after acceptance.
- Streaming: out_ready=1, send 8'h01..8'h10 back-to-back -> outputs 01..10 in order, one per cycle, starting 3 cycles after the first accept. count stays 3 at steady state; no gaps.
- Backpressure fill: out_ready=0, send A1, A2, A3, A4 -> A1..A3 accepted, in_ready=0 while A4 is presented, count=3, out_data=A1 held stable. Raise out_ready -> A4 accepted in the same cycle A1 leaves, order A1..A4.
- Bubble collapse: send B1, idle 2 cycles, send B2 with out_ready=0 -> B1 at output, B2 in stage 1, count=2. Then out_ready=1 -> B1, B2 on consecutive cycles.
- Flush: with count=3 and out_ready=0, pulse flush one cycle with in_valid=1, in_data=8'hCC -> in_ready=0 that cycle, count=0 and out_valid=0 next cycle. 8'hCC is never emitted.
- Async reset mid-stream: drop rst between clock edges while streaming -> out_valid and count go to 0 without waiting for clk. After release, the stream resumes cleanly from the next accepted word.

Source files
------------

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: STAGES-deep register pipeline with valid/ready handshake.
// Each stage holds one word plus a valid bit; bubbles are squeezed out even
// while the output is stalled, so the chain buffers up to STAGES words.
// Outputs are taken straight from the last stage registers. The only
// combinational path is the ready chain from out_ready back to in_ready.
module pipe_reg_elastic #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 3,
  localparam int CW     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  // Stage storage: index 0 is the input side, STAGES-1 the output side.
  logic [STAGES-1:0] v_reg;
  logic [WIDTH-1:0]  d_reg [STAGES];
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     pop_count;

  // Per-stage advance enables and the word each stage would load.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic              accept;
  logic              deliver;

  // Stage 0 is fed by the upstream port, every other stage by its predecessor.
  assign src_v[0] = in_valid;
  assign src_d[0] = in_data;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_src
      assign src_v[gi] = v_reg[gi-1];
      assign src_d[gi] = d_reg[gi-1];
    end
  endgenerate

  // Ready ripples from the output back: a stage may load when it is empty
  // or when the stage after it is moving on this edge.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v_reg[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = !v_reg[i] | adv[i+1];
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign accept    = in_valid & in_ready;
  assign deliver   = v_reg[STAGES-1] & out_ready;

  assign out_valid = v_reg[STAGES-1];
  assign out_data  = d_reg[STAGES-1];
  assign count     = count_reg;

  // Occupancy tracks accepts minus deliveries; both in one cycle cancel out.
  always_comb begin
    count_next = count_reg;
    if (accept && !deliver) begin
      count_next = count_reg + CW'(1);
    end else if (deliver && !accept) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Stage update: valids follow the advance enables; data only loads real
  // words so the data path does not toggle on bubbles. Flush clears the
  // valids and the count but leaves data untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_reg     <= '0;
      count_reg <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_reg[i] <= '0;
      end
    end else if (flush) begin
      v_reg     <= '0;
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          v_reg[i] <= src_v[i];
          if (src_v[i]) begin
            d_reg[i] <= src_d[i];
          end
        end
      end
    end
  end

  // Number of occupied stages, used to cross-check the running count.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < STAGES; i++) begin
      pop_count = pop_count + CW'(v_reg[i]);
    end
  end

  // The running count must always equal the number of valid stages.
  a_count_matches: assert property (@(posedge clk) disable iff (!rst)
    count_reg == pop_count);

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic (WIDTH=8, STAGES=3). Inputs change 1ns
// after each rising edge; outputs are checked in the same quiet window.
module tb_pipe_reg_elastic;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] count;

  int total;
  int bad;

  pipe_reg_elastic #(.WIDTH(8), .STAGES(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    // One word: accepted at the first edge, visible after the third.
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 2'd1) begin bad++; $display("FAIL latency_e1 got v=%b c=%0d want v=0 c=1", out_valid, count); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_e2 got v=%b want v=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin bad++; $display("FAIL latency_e3 got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
    $display("reset: word %h out after 3 edges", out_data);
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL latency_drain got v=%b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      if (c < 16) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready c=%0d got=%b want=1", c, in_ready); end
      end
      step();
      // Word presented in cycle c-2 sits at the output after this edge.
      if (c >= 2 && c < 18) begin
        total++; if (out_valid !== 1'b1 || out_data !== 8'(c - 1)) begin bad++; $display("FAIL stream_out c=%0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, 8'(c - 1)); end
        $display("stream: out %h", out_data);
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle c=%0d got v=%b want v=0", c, out_valid); end
      end
      if (c >= 2 && c <= 15) begin
        total++; if (count !== 2'd3) begin bad++; $display("FAIL stream_count c=%0d got=%0d want=3", c, count); end
      end
    end
    in_valid = 1'b0;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL stream_end_count got=%0d want=0", count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(k);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready k=%0d got=%b want=1", k, in_ready); end
      step();
    end
    in_data = 8'hA4;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
    total++; if (count !== 2'd3) begin bad++; $display("FAIL bp_full_count got=%0d want=3", count); end
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold k=%0d got v=%b d=%h r=%b want v=1 d=a1 r=0", k, out_valid, out_data, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out_data !== 8'hA2 || count !== 2'd3) begin bad++; $display("FAIL bp_shift got d=%h c=%0d want d=a2 c=3", out_data, count); end
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA3 + 8'(k)) begin bad++; $display("FAIL bp_order k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'hA3 + 8'(k)); end
      $display("backpressure: out %h", out_data);
    end
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bp_drain got v=%b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1;
    step();
    in_valid = 1'b0;
    step(); step();
    in_valid = 1'b1; in_data = 8'hB2;
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hB1 || count !== 2'd2) begin bad++; $display("FAIL bubble_state got v=%b d=%h c=%0d want v=1 d=b1 c=2", out_valid, out_data, count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hB2 || count !== 2'd1) begin bad++; $display("FAIL bubble_second got v=%b d=%h c=%0d want v=1 d=b2 c=1", out_valid, out_data, count); end
    $display("bubble: out %h after b1", out_data);
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL bubble_drain got v=%b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hC1 + 8'(k);
      step();
    end
    total++; if (count !== 2'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", count); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL flush_clear got v=%b c=%0d want v=0 c=0", out_valid, count); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit k=%0d got v=%b d=%h want v=0", k, out_valid, out_data); end
    end
    $display("flush: pipeline empty, cc dropped");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hD1 + 8'(k);
      step();
    end
    total++; if (count !== 2'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got v=%b c=%0d want v=1 c=3", out_valid, count); end
    // Drop reset mid-cycle, well away from any edge.
    #2;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 8'h00) begin bad++; $display("FAIL areset_immediate got v=%b c=%0d d=%h want v=0 c=0 d=00", out_valid, count, out_data); end
    step();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hE1;
    step();
    in_data = 8'hE2;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_resume_early got v=%b want v=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hE1) begin bad++; $display("FAIL areset_resume_first got v=%b d=%h want v=1 d=e1", out_valid, out_data); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'hE2) begin bad++; $display("FAIL areset_resume_second got v=%b d=%h want v=1 d=e2", out_valid, out_data); end
    $display("async reset: resumed with %h", out_data);
    step();
    total++; if (out_valid !== 1'b0 || count !== 2'd0) begin bad++; $display("FAIL areset_drain got v=%b c=%0d want v=0 c=0", out_valid, count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
